// File: rtl/gpr_cdb_arbiter_pkg.sv
// Shared types for the GPR common data bus: bus payload, tag width and default unit count.
package gpr_cdb_arbiter_pkg;

  localparam int unsigned ROB_WIDTH      = 6;
  localparam int unsigned CDB_DATA_WIDTH = 32;
  localparam int unsigned N_GPR_CDB_UNIT = 4;

  typedef struct packed {
    logic                      valid;
    logic [ROB_WIDTH-1:0]      tag;
    logic [CDB_DATA_WIDTH-1:0] data;
  } cdb_t;

endpackage

// File: rtl/req_if.sv
// Valid/ready dispatch handshake between a reservation station and the CDB arbiter.
interface req_if;
  logic valid;
  logic ready;

  modport arb  (input valid, output ready);
  modport unit (output valid, input ready);
endinterface

// File: rtl/gpr_cdb_arbiter_rr_select.sv
// Rotating-priority selector: first requester at or after ptr, wrapping modulo N.
module gpr_cdb_arbiter_rr_select #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx
);
  localparam int unsigned IDX_W = $clog2(N);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] pos;
  logic             found;

  // Walk offsets from ptr; the extra sum bit lets non-power-of-two N wrap correctly.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    sum       = '0;
    pos       = '0;
    for (int unsigned k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(N)) begin
        sum = sum - (IDX_W+1)'(N);
      end
      pos = IDX_W'(sum);
      if (!found && req[pos]) begin
        found      = 1'b1;
        grant[pos] = 1'b1;
        grant_idx  = pos;
      end
    end
  end

endmodule

// File: rtl/gpr_cdb_arbiter.sv
// GPR common data bus arbiter: zero-latency grant, one-cycle registered broadcast.
// GPR_CDB_RR_EN selects round-robin priority; otherwise lowest index wins.
module gpr_cdb_arbiter
  import gpr_cdb_arbiter_pkg::*;
#(
  parameter int unsigned N_UNIT = N_GPR_CDB_UNIT
) (
  input  logic  clk,
  input  logic  reset,
  req_if.arb    unit_req [N_UNIT],
  input  cdb_t  unit_result [N_UNIT],
  output cdb_t  gpr_cdb
);
  localparam int unsigned IDX_W = $clog2(N_UNIT);

  logic [N_UNIT-1:0] req_vec;
  logic [N_UNIT-1:0] grant_oh;
  logic [N_UNIT-1:0] unused_result_valid;
  logic [IDX_W-1:0]  grant_sel;
  logic [IDX_W-1:0]  sel_ptr;
  logic              grant_any;
  logic              grant_valid;
  logic [IDX_W-1:0]  grant_idx;

  for (genvar g = 0; g < N_UNIT; g++) begin : g_unit
    assign req_vec[g]             = unit_req[g].valid;
    assign unit_req[g].ready      = grant_oh[g];
    assign unused_result_valid[g] = unit_result[g].valid;
  end

  assign grant_any = |grant_oh;

  gpr_cdb_arbiter_rr_select #(
    .N (N_UNIT)
  ) u_select (
    .req       (req_vec),
    .ptr       (sel_ptr),
    .grant     (grant_oh),
    .grant_idx (grant_sel)
  );

`ifdef GPR_CDB_RR_EN
  logic [IDX_W-1:0] rr_ptr;

  // Next search starts just past the last winner; a grant during reset is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (grant_any) begin
      rr_ptr <= (grant_sel == IDX_W'(N_UNIT - 1)) ? '0 : grant_sel + IDX_W'(1);
    end
  end

  assign sel_ptr = rr_ptr;
`else
  assign sel_ptr = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      grant_valid <= 1'b0;
      grant_idx   <= '0;
    end else begin
      grant_valid <= grant_any;
      grant_idx   <= grant_sel;
    end
  end

  // The winner registered its result at the grant edge; forward it this cycle.
  always_comb begin
    gpr_cdb       = 'x;
    gpr_cdb.valid = grant_valid;
    if (grant_valid) begin
      gpr_cdb.tag  = unit_result[grant_idx].tag;
      gpr_cdb.data = unit_result[grant_idx].data;
    end
  end

endmodule

// File: tb/tb_gpr_cdb_arbiter.sv
// Bench for gpr_cdb_arbiter (N_UNIT=4); expectations follow GPR_CDB_RR_EN if defined.
module tb_gpr_cdb_arbiter;
  import gpr_cdb_arbiter_pkg::*;

`ifdef GPR_CDB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    logic [3:0] vld;
    int         exp_g;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] valid_v = '0;
  logic [3:0] ready_v;
  cdb_t       entry [4];
  cdb_t       res_q [4];
  cdb_t       gpr_cdb;
  cdb_t       sb_q [$];
  int         total = 0;
  int         bad = 0;
  int         seq = 0;
  vec_t       vecs [17];

  req_if unit_req [4] ();

  for (genvar g = 0; g < 4; g++) begin : g_if
    assign unit_req[g].valid = valid_v[g];
    assign ready_v[g]        = unit_req[g].ready;
  end

  gpr_cdb_arbiter #(.N_UNIT(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .unit_req    (unit_req),
    .unit_result (res_q),
    .gpr_cdb     (gpr_cdb)
  );

  always #5 clk = ~clk;

  // Unit model: a granted unit registers its dispatched entry at the grant edge.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (ready_v[i]) res_q[i] <= entry[i];
    end
  end

  task automatic step(input logic rst, input logic [3:0] vld, input int exp_g,
                      input string name, input int ov_unit, input cdb_t ov_e);
    cdb_t       exp_bus;
    cdb_t       push_e;
    logic [3:0] exp_rdy;
    @(posedge clk);
    #1;
    reset   = rst;
    valid_v = vld;
    for (int i = 0; i < 4; i++) begin
      entry[i].valid = 1'b0;
      entry[i].tag   = ROB_WIDTH'(seq * 4 + i);
      entry[i].data  = 32'hA500_0000 | 32'(seq * 16 + i);
    end
    if (ov_unit >= 0) entry[ov_unit] = ov_e;
    seq++;
    #4;
    if (sb_q.size() > 0) begin
      exp_bus = sb_q.pop_front();
      total++;
      if (gpr_cdb.valid !== exp_bus.valid) begin
        bad++;
        $display("FAIL %s bus.valid: got %b want %b", name, gpr_cdb.valid, exp_bus.valid);
      end else if (exp_bus.valid) begin
        total++;
        if (gpr_cdb.tag !== exp_bus.tag || gpr_cdb.data !== exp_bus.data) begin
          bad++;
          $display("FAIL %s bus.payload: got tag=%0d data=%h want tag=%0d data=%h",
                   name, gpr_cdb.tag, gpr_cdb.data, exp_bus.tag, exp_bus.data);
        end
      end
    end
    exp_rdy = (exp_g < 0) ? 4'b0000 : (4'b0001 << exp_g);
    total++;
    if (ready_v !== exp_rdy) begin
      bad++;
      $display("FAIL %s ready: got %b want %b", name, ready_v, exp_rdy);
    end
    push_e       = '0;
    if (!rst && exp_g >= 0) begin
      push_e       = entry[exp_g];
      push_e.valid = 1'b1;
    end
    sb_q.push_back(push_e);
  endtask

  initial begin
    cdb_t none;
    cdb_t single;
    none   = '0;
    single = '0;
    single.tag  = ROB_WIDTH'(5);
    single.data = 32'h0000_0010;

    vecs[0]  = '{4'b1111, RR ? 3 : 0};
    vecs[1]  = '{4'b1111, 0};
    vecs[2]  = '{4'b1111, RR ? 1 : 0};
    vecs[3]  = '{4'b1111, RR ? 2 : 0};
    vecs[4]  = '{4'b1111, RR ? 3 : 0};
    vecs[5]  = '{4'b1111, 0};
    vecs[6]  = '{4'b0000, -1};
    vecs[7]  = '{4'b1001, RR ? 3 : 0};
    vecs[8]  = '{4'b1001, 0};
    vecs[9]  = '{4'b1001, RR ? 3 : 0};
    vecs[10] = '{4'b1010, 1};
    vecs[11] = '{4'b1010, RR ? 3 : 1};
    vecs[12] = '{4'b1010, 1};
    vecs[13] = '{4'b0100, 2};
    vecs[14] = '{4'b0001, 0};
    vecs[15] = '{4'b0110, 1};
    vecs[16] = '{4'b0110, RR ? 2 : 1};

    step(1'b1, 4'b0000, -1, "reset", -1, none);
    step(1'b1, 4'b0000, -1, "reset", -1, none);
    for (int i = 0; i < 10; i++) step(1'b0, 4'b0000, -1, "idle", -1, none);

    step(1'b0, 4'b0100, 2, "single", 2, single);

    for (int i = 0; i < 17; i++) begin
      step(1'b0, vecs[i].vld, vecs[i].exp_g, $sformatf("vec%0d", i), -1, none);
    end

    // Reset lands on a grant: no broadcast follows and the pointer restarts at 0.
    step(1'b1, 4'b0001, 0, "rst_grant", -1, none);
    step(1'b0, 4'b0000, -1, "post_rst", -1, none);
    step(1'b0, 4'b1111, 0, "ptr_zero", -1, none);
    step(1'b0, 4'b1111, RR ? 1 : 0, "ptr_next", -1, none);
    step(1'b0, 4'b0000, -1, "drain", -1, none);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
